// File: rtl/stack_pkg.sv
// Shared encodings for the stack pointer / access controller.
// DEPTH defaults to the stack RAM depth so both sides agree.
`ifndef RAM_DEPTH
`define RAM_DEPTH 1024
`endif

package stack_pkg;

    localparam int DEPTH_DEF = `RAM_DEPTH;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_POP2 = 2'b10,
        OP_PEEK = 2'b11
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // What the registered response slot must present next cycle
    typedef enum logic [1:0] {
        RK_PUSH  = 2'b00,
        RK_READ  = 2'b01,
        RK_POP2  = 2'b10,
        RK_FAULT = 2'b11
    } rsp_kind_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack pointer and access controller in front of a dual-port stack RAM.
// Zero-sweeps the RAM after reset, then serves push/pop/pop2/peek.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AW         = $clog2(DEPTH) + 1,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [31:0]   cmd_data,
    input  logic [AW-1:0] cmd_off,
    input  logic          sp_load,
    input  logic [AW-1:0] sp_load_val,
    input  logic          err_clr,
    output logic          rsp_valid,
    output logic [31:0]   rsp_a,
    output logic [31:0]   rsp_b,
    output logic          rsp_err,
    output logic [AW-1:0] sp,
    output logic          empty,
    output logic          full,
    output logic          err_ovf,
    output logic          err_udf,
    output logic [31:0]   ram_addr_a,
    output logic [31:0]   ram_datain_a,
    output logic          ram_wr_a,
    output logic [31:0]   ram_addr_b,
    input  logic [31:0]   ram_data_a,
    input  logic [31:0]   ram_data_b
);

    localparam logic [AW-1:0] LP_DEPTH = AW'(DEPTH);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LP_ONE   = AW'(1);
    localparam logic [AW-1:0] LP_TWO   = AW'(2);

    state_e    r_state;
    state_e    w_state_nxt;
    logic [AW-1:0] r_sp;
    logic [AW-1:0] r_cnt;
    logic      r_ovf;
    logic      r_udf;
    logic      r_rsp_valid;
    rsp_kind_e r_kind;
    logic [31:0] r_push_data;

    logic      w_ready;
    logic      w_acc;
    op_e       w_op;
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_sp_nxt;
    logic [AW-1:0] w_addr_a;
    logic [AW-1:0] w_addr_b;
    logic [31:0]   w_din;
    logic      w_wr_a;
    logic      w_set_ovf;
    logic      w_set_udf;
    rsp_kind_e w_kind;

    assign w_op    = op_e'(cmd_op);
    assign w_ready = (r_state == ST_RUN) & ~sp_load;
    assign w_acc   = cmd_valid & w_ready;
    assign w_top   = (r_sp == '0) ? '0 : r_sp - LP_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_sp_nxt    = r_sp;
        w_addr_a    = w_top;
        w_addr_b    = '0;
        w_din       = '0;
        w_wr_a      = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_udf   = 1'b0;
        w_kind      = RK_READ;
        if (r_state == ST_INIT) begin
            // Write strobe held low while reset is asserted
            w_wr_a   = rst;
            w_addr_a = r_cnt;
            if (r_cnt == LP_LAST) begin
                w_state_nxt = ST_RUN;
            end
        end else if (sp_load) begin
            if (sp_load_val > LP_DEPTH) begin
                w_set_ovf = 1'b1;
            end else begin
                w_sp_nxt = sp_load_val;
            end
        end else if (cmd_valid) begin
            unique case (w_op)
                OP_PUSH: begin
                    if (r_sp < LP_DEPTH) begin
                        w_wr_a   = 1'b1;
                        w_addr_a = r_sp;
                        w_din    = cmd_data;
                        w_sp_nxt = r_sp + LP_ONE;
                        w_kind   = RK_PUSH;
                    end else begin
                        w_set_ovf = 1'b1;
                        w_kind    = RK_FAULT;
                    end
                end
                OP_POP: begin
                    if (r_sp >= LP_ONE) begin
                        w_addr_a = r_sp - LP_ONE;
                        w_sp_nxt = r_sp - LP_ONE;
                    end else begin
                        w_set_udf = 1'b1;
                        w_kind    = RK_FAULT;
                    end
                end
                OP_POP2: begin
                    if (r_sp >= LP_TWO) begin
                        w_addr_a = r_sp - LP_ONE;
                        w_addr_b = r_sp - LP_TWO;
                        w_sp_nxt = r_sp - LP_TWO;
                        w_kind   = RK_POP2;
                    end else begin
                        w_set_udf = 1'b1;
                        w_kind    = RK_FAULT;
                    end
                end
                OP_PEEK: begin
                    if (cmd_off < r_sp) begin
                        w_addr_a = r_sp - LP_ONE - cmd_off;
                    end else begin
                        w_set_udf = 1'b1;
                        w_kind    = RK_FAULT;
                    end
                end
                default: w_kind = RK_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= INIT_CLEAR ? ST_INIT : ST_RUN;
            r_sp    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sp    <= w_sp_nxt;
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + LP_ONE;
            end
            // New fault in the same cycle as a clear wins
            r_ovf <= (r_ovf & ~err_clr) | w_set_ovf;
            r_udf <= (r_udf & ~err_clr) | w_set_udf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_kind      <= RK_READ;
            r_push_data <= '0;
        end else begin
            r_rsp_valid <= w_acc;
            if (w_acc) begin
                r_kind      <= w_kind;
                r_push_data <= cmd_data;
            end
        end
    end

    always_comb begin
        rsp_a = '0;
        rsp_b = '0;
        if (r_rsp_valid) begin
            unique case (r_kind)
                RK_PUSH:  rsp_a = r_push_data;
                RK_READ:  rsp_a = ram_data_a;
                RK_POP2: begin
                    rsp_a = ram_data_a;
                    rsp_b = ram_data_b;
                end
                RK_FAULT: rsp_a = '0;
                default:  rsp_a = '0;
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_valid & (r_kind == RK_FAULT);
    assign cmd_ready    = w_ready;
    assign sp           = r_sp;
    assign empty        = (r_sp == '0);
    assign full         = (r_sp == LP_DEPTH);
    assign err_ovf      = r_ovf;
    assign err_udf      = r_udf;
    assign ram_addr_a   = 32'(w_addr_a);
    assign ram_addr_b   = 32'(w_addr_b);
    assign ram_datain_a = w_din;
    assign ram_wr_a     = w_wr_a;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl with DEPTH=8 and a behavioural RAM.
// Stimulus pushes expected responses; a monitor pops and compares.
module tb_stack_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [31:0]   cmd_data = '0;
    logic [AW-1:0] cmd_off = '0;
    logic          sp_load = 1'b0;
    logic [AW-1:0] sp_load_val = '0;
    logic          err_clr = 1'b0;
    logic          rsp_valid;
    logic [31:0]   rsp_a;
    logic [31:0]   rsp_b;
    logic          rsp_err;
    logic [AW-1:0] sp;
    logic          empty;
    logic          full;
    logic          err_ovf;
    logic          err_udf;
    logic [31:0]   ram_addr_a;
    logic [31:0]   ram_datain_a;
    logic          ram_wr_a;
    logic [31:0]   ram_addr_b;
    logic [31:0]   ram_data_a = '0;
    logic [31:0]   ram_data_b = '0;

    logic [31:0] mem [DEPTH];
    logic        poison = 1'b1;
    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_off(cmd_off),
        .sp_load(sp_load), .sp_load_val(sp_load_val), .err_clr(err_clr),
        .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_err(rsp_err), .sp(sp), .empty(empty), .full(full),
        .err_ovf(err_ovf), .err_udf(err_udf),
        .ram_addr_a(ram_addr_a), .ram_datain_a(ram_datain_a),
        .ram_wr_a(ram_wr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM; poison preloads non-zero garbage
    always @(posedge clk) begin
        ram_data_a <= mem[ram_addr_a[2:0]];
        ram_data_b <= mem[ram_addr_b[2:0]];
        if (poison) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD_0000 | i;
        end else if (ram_wr_a) begin
            mem[ram_addr_a[2:0]] <= ram_datain_a;
        end
    end

    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got a=%h b=%h err=%b, none expected",
                         rsp_a, rsp_b, rsp_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rsp_a !== e.a || rsp_b !== e.b || rsp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL rsp: got a=%h b=%h err=%b, want a=%h b=%h err=%b",
                             rsp_a, rsp_b, rsp_err, e.a, e.b, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] d,
                         input logic [AW-1:0] off, input logic [31:0] ea,
                         input logic [31:0] eb, input logic ee);
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_off   = off;
        e.a = ea;
        e.b = eb;
        e.err = ee;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic wait_ready(input string name, input int want);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk(name, 32'(n), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nz;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wr_a", 32'(ram_wr_a), 32'd0);
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_errs", {30'd0, err_ovf, err_udf}, 32'd0);
        poison = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        wait_ready("sweep_cycles", DEPTH);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 32'd0) nz++;
        chk("sweep_zeroed", 32'(nz), 32'd0);
        chk("run_sp", 32'(sp), 32'd0);
        chk("run_empty", 32'(empty), 32'd1);

        issue(2'b00, 32'hA, '0, 32'hA, 32'h0, 1'b0);
        issue(2'b00, 32'hB, '0, 32'hB, 32'h0, 1'b0);
        issue(2'b00, 32'hC, '0, 32'hC, 32'h0, 1'b0);
        issue(2'b10, 32'h0, '0, 32'hC, 32'hB, 1'b0);
        idle();
        chk("pop2_sp", 32'(sp), 32'd1);
        issue(2'b01, 32'h0, '0, 32'hA, 32'h0, 1'b0);
        idle();
        chk("pop_sp", 32'(sp), 32'd0);
        chk("pop_empty", 32'(empty), 32'd1);

        for (int i = 1; i <= DEPTH; i++)
            issue(2'b00, 32'(i), '0, 32'(i), 32'h0, 1'b0);
        issue(2'b00, 32'hFF, '0, 32'h0, 32'h0, 1'b1);
        idle();
        chk("ovf_sp", 32'(sp), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(err_ovf), 32'd1);
        chk("ovf_nowrite", mem[7], 32'd8);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("ovf_clr", 32'(err_ovf), 32'd0);

        for (int i = DEPTH; i >= 2; i--)
            issue(2'b01, 32'h0, '0, 32'(i), 32'h0, 1'b0);
        idle();
        chk("drain_sp", 32'(sp), 32'd1);
        issue(2'b10, 32'h0, '0, 32'h0, 32'h0, 1'b1);
        idle();
        chk("udf_flag", 32'(err_udf), 32'd1);
        chk("udf_sp", 32'(sp), 32'd1);
        issue(2'b11, 32'h0, 4'd1, 32'h0, 32'h0, 1'b1);
        issue(2'b11, 32'h0, 4'd0, 32'h1, 32'h0, 1'b0);
        idle();
        chk("peek_sp", 32'(sp), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("udf_clr", 32'(err_udf), 32'd0);

        issue(2'b00, 32'h55, '0, 32'h55, 32'h0, 1'b0);
        issue(2'b11, 32'h0, 4'd0, 32'h55, 32'h0, 1'b0);
        issue(2'b11, 32'h0, 4'd1, 32'h1, 32'h0, 1'b0);
        idle();
        chk("raw_sp", 32'(sp), 32'd2);

        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = 2'b11;
        cmd_off     = '0;
        sp_load     = 1'b1;
        sp_load_val = 4'd5;
        #1;
        chk("load_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        sp_load   = 1'b0;
        #1;
        chk("load_sp", 32'(sp), 32'd5);
        @(negedge clk);
        sp_load     = 1'b1;
        sp_load_val = 4'd9;
        @(negedge clk);
        sp_load = 1'b0;
        #1;
        chk("load_bad_sp", 32'(sp), 32'd5);
        chk("load_bad_ovf", 32'(err_ovf), 32'd1);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        rst = 1'b0;
        #1;
        chk("rst2_wr_a", 32'(ram_wr_a), 32'd0);
        chk("rst2_ovf", 32'(err_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("sweep_start", ram_addr_a, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("sweep_mid", ram_addr_a, 32'd3);
        rst = 1'b0;
        #1;
        chk("abort_wr_a", 32'(ram_wr_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("restart_addr", ram_addr_a, 32'd0);
        chk("restart_wr", 32'(ram_wr_a), 32'd1);
        wait_ready("resweep_cycles", DEPTH);
        chk("resweep_sp", 32'(sp), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
